// File: rtl/de2_pio_pkg.sv
// Shared constants for the DE2 input PIO: register addresses and edge-mode encodings.
package de2_pio_pkg;

    // Word addresses on the Avalon-MM slave
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // EDGE_MODE encodings
    localparam int EDGE_LEVEL = 0;
    localparam int EDGE_RISE  = 1;
    localparam int EDGE_FALL  = 2;
    localparam int EDGE_ANY   = 3;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser, previous-value register, priming logic and edge event generation.
module pio_sync_edge
    import de2_pio_pkg::*;
#(
    parameter int WIDTH       = 18,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] edge_evt
);

    // The chain resets to zero, so an input held high through reset would look like a
    // rising edge once it has propagated. Events stay suppressed until the chain and the
    // prev register both hold genuinely sampled data: SYNC_STAGES+1 clocks after release.
    localparam int PRIME_CYCLES = SYNC_STAGES + 1;
    localparam int PW           = $clog2(PRIME_CYCLES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]                  prev;
    logic [PW-1:0]                     prime_cnt;
    logic                              primed;
    logic [WIDTH-1:0]                  rise;
    logic [WIDTH-1:0]                  fall;
    logic [WIDTH-1:0]                  edge_sel;

    assign sync   = chain[SYNC_STAGES-1];
    assign primed = (prime_cnt == PW'(PRIME_CYCLES));
    assign rise   = sync & ~prev;
    assign fall   = ~sync & prev;

    // Shift raw inputs through the synchroniser flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], in_port};
        end
    end

    // Remember last cycle's synchronised value for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= sync;
        end
    end

    // Count clocks since reset release until the pipeline holds real samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt <= '0;
        end else if (!primed) begin
            prime_cnt <= prime_cnt + PW'(1);
        end
    end

    // Pick the event type for this build; level mode still records rising edges
    always_comb begin
        edge_sel = rise;
        case (EDGE_MODE)
            EDGE_FALL: edge_sel = fall;
            EDGE_ANY:  edge_sel = rise | fall;
            default:   edge_sel = rise;
        endcase
        edge_evt = primed ? edge_sel : '0;
    end

endmodule

// File: rtl/de2_pio_edgecap_in.sv
// Avalon-MM input PIO with synchronised inputs, sticky edge capture (write-1-to-clear),
// interrupt mask and registered interrupt request.
module de2_pio_edgecap_in
    import de2_pio_pkg::*;
#(
    parameter int WIDTH       = 18,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq,
    output logic [31:0]      readdata
);

    // Bus handshake: a write is accepted on any clock where chipselect=1 and write_n=0;
    // there are no wait states. readdata is registered from address every clock with no
    // chipselect qualification, so read data appears one clock after the address.

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic             wr_en;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] mask_nxt;
    logic [WIDTH-1:0] edge_cap_nxt;
    logic             irq_nxt;
    logic [31:0]      rd_nxt;
    logic             unused_wdata;

    // Upper writedata bits are meaningful only for wide builds
    assign unused_wdata = ^writedata;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .sync     (sync),
        .edge_evt (edge_evt)
    );

    // Next-state for mask, capture and irq; irq looks at next-state values so it moves
    // on the same edge as the capture, clear or mask write that causes it
    always_comb begin
        wr_en        = chipselect & ~write_n;
        clr          = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
        mask_nxt     = (wr_en && address == ADDR_MASK) ? writedata[WIDTH-1:0] : irq_mask;
        edge_cap_nxt = edge_evt | (edge_cap & ~clr);
        if (EDGE_MODE == EDGE_LEVEL) begin
            irq_nxt = |(sync & mask_nxt);
        end else begin
            irq_nxt = |(edge_cap_nxt & mask_nxt);
        end
    end

    // Read mux; unused upper bits and the reserved word read as zero
    always_comb begin
        rd_nxt = '0;
        case (address)
            ADDR_DATA: rd_nxt = 32'(sync);
            ADDR_MASK: rd_nxt = 32'(irq_mask);
            ADDR_EDGE: rd_nxt = 32'(edge_cap);
            default:   rd_nxt = '0;
        endcase
    end

    // Register state: mask, sticky capture, irq and read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
            edge_cap <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            irq_mask <= mask_nxt;
            edge_cap <= edge_cap_nxt;
            irq      <= irq_nxt;
            readdata <= rd_nxt;
        end
    end

endmodule

// File: tb/tb_de2_pio_edgecap_in.sv
// Directed bench for de2_pio_edgecap_in: one instance per edge mode (rise, any, level)
// sharing bus and input stimulus, each checked against hand-computed values.
module tb_de2_pio_edgecap_in;
    import de2_pio_pkg::*;

    localparam int W = 18;

    logic          clk;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic          irq_m1, irq_m3, irq_m0;
    logic [31:0]   rd_m1, rd_m3, rd_m0;

    int checks = 0;
    int errors = 0;
    logic [31:0] r1, r3, r0;

    typedef struct {
        logic        cs;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    de2_pio_edgecap_in #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_MODE(1)) u_m1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .irq(irq_m1), .readdata(rd_m1)
    );

    de2_pio_edgecap_in #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_MODE(3)) u_m3 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .irq(irq_m3), .readdata(rd_m3)
    );

    de2_pio_edgecap_in #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_MODE(0)) u_m0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .irq(irq_m0), .readdata(rd_m0)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_cycle(input logic cs, input logic wn, input logic [1:0] a,
                             input logic [31:0] d);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_cycle(1'b1, 1'b0, a, d);
    endtask

    task automatic bus_read(input logic [1:0] a);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = a;
        tick();
        r1 = rd_m1;
        r3 = rd_m3;
        r0 = rd_m0;
    endtask

    // Safety net in case the run ever stalls
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        // Register access table (rise-mode instance, in_port = 0, capture clear)
        vecs[0] = '{cs:1'b1, wr:1'b1, addr:ADDR_MASK, wdata:32'hFFFF_FFFF, raddr:ADDR_MASK, exp:32'h0003_FFFF};
        vecs[1] = '{cs:1'b1, wr:1'b1, addr:ADDR_MASK, wdata:32'h0001_2345, raddr:ADDR_MASK, exp:32'h0001_2345};
        vecs[2] = '{cs:1'b1, wr:1'b1, addr:ADDR_RSVD, wdata:32'hFFFF_FFFF, raddr:ADDR_RSVD, exp:32'h0000_0000};
        vecs[3] = '{cs:1'b0, wr:1'b0, addr:ADDR_DATA, wdata:32'h0000_0000, raddr:ADDR_MASK, exp:32'h0001_2345};
        vecs[4] = '{cs:1'b0, wr:1'b0, addr:ADDR_DATA, wdata:32'h0000_0000, raddr:ADDR_DATA, exp:32'h0000_0000};
        vecs[5] = '{cs:1'b1, wr:1'b1, addr:ADDR_MASK, wdata:32'h0000_0000, raddr:ADDR_MASK, exp:32'h0000_0000};
        vecs[6] = '{cs:1'b1, wr:1'b1, addr:ADDR_EDGE, wdata:32'hFFFF_FFFF, raddr:ADDR_EDGE, exp:32'h0000_0000};
        vecs[7] = '{cs:1'b0, wr:1'b1, addr:ADDR_MASK, wdata:32'h0000_0ABC, raddr:ADDR_MASK, exp:32'h0000_0000};
        vecs[8] = '{cs:1'b1, wr:1'b0, addr:ADDR_MASK, wdata:32'h0000_0001, raddr:ADDR_MASK, exp:32'h0000_0000};

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = ADDR_DATA;
        writedata  = '0;
        in_port    = 18'h3FFFF;

        // 1: reset with all inputs held high
        repeat (3) tick();
        check("reset_readdata", rd_m1, 32'h0);
        check("reset_irq", {29'h0, irq_m1, irq_m3, irq_m0}, 32'h0);
        reset_n = 1'b1;
        repeat (5) tick();
        check("post_reset_irq", {29'h0, irq_m1, irq_m3, irq_m0}, 32'h0);
        bus_read(ADDR_EDGE);
        check("post_reset_edge_m1", r1, 32'h0);
        check("post_reset_edge_m3", r3, 32'h0);
        bus_read(ADDR_DATA);
        check("post_reset_data", r1, 32'h0003_FFFF);

        in_port = '0;
        repeat (5) tick();

        // Table-driven register access
        for (int i = 0; i < 9; i++) begin
            bus_cycle(vecs[i].cs, ~vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].raddr);
            check($sformatf("vec%0d", i), r1, vecs[i].exp);
        end

        // 2: rising edge on bit 0, irq timing, then write-1-to-clear
        bus_write(ADDR_MASK, 32'h1);
        in_port = 18'h00001;
        tick();
        check("m1_irq_e1", {31'h0, irq_m1}, 32'h0);
        tick();
        check("m1_irq_e2", {31'h0, irq_m1}, 32'h0);
        tick();
        check("m1_irq_e3", {31'h0, irq_m1}, 32'h1);
        bus_read(ADDR_EDGE);
        check("m1_edge_set", r1, 32'h1);
        bus_write(ADDR_EDGE, 32'h1);
        check("m1_irq_cleared", {31'h0, irq_m1}, 32'h0);
        bus_read(ADDR_EDGE);
        check("m1_edge_cleared", r1, 32'h0);

        // 3: edge and clear on the same clock, set wins
        in_port = 18'h0;
        repeat (4) tick();
        in_port = 18'h1;
        repeat (3) tick();
        check("m1_irq_pending", {31'h0, irq_m1}, 32'h1);
        in_port = 18'h0;
        repeat (4) tick();
        in_port = 18'h1;
        tick();
        tick();
        bus_write(ADDR_EDGE, 32'h1);
        check("m1_set_wins_irq", {31'h0, irq_m1}, 32'h1);
        bus_read(ADDR_EDGE);
        check("m1_set_wins_edge", r1, 32'h1);
        bus_write(ADDR_EDGE, 32'h1);
        check("m1_late_clear_irq", {31'h0, irq_m1}, 32'h0);

        // 4: any-edge mode on bit 5, masked then unmasked
        bus_write(ADDR_EDGE, 32'h3FFFF);
        bus_write(ADDR_MASK, 32'h0);
        in_port = 18'h00021;
        repeat (4) tick();
        bus_read(ADDR_EDGE);
        check("m3_edge_rise", r3, 32'h20);
        check("m1_edge_rise", r1, 32'h20);
        check("m3_irq_masked_rise", {31'h0, irq_m3}, 32'h0);
        bus_write(ADDR_EDGE, 32'h20);
        in_port = 18'h00001;
        repeat (4) tick();
        bus_read(ADDR_EDGE);
        check("m3_edge_fall", r3, 32'h20);
        check("m1_edge_fall_ignored", r1, 32'h0);
        check("m3_irq_masked_fall", {31'h0, irq_m3}, 32'h0);
        bus_write(ADDR_MASK, 32'h20);
        check("m3_irq_unmask", {31'h0, irq_m3}, 32'h1);
        check("m1_irq_unmask", {31'h0, irq_m1}, 32'h0);

        // 5: level mode on bit 1; masking away bit 5 drops the any-edge irq at once
        bus_write(ADDR_MASK, 32'h2);
        check("m3_irq_remask", {31'h0, irq_m3}, 32'h0);
        in_port = 18'h00003;
        tick();
        tick();
        check("m0_irq_e2", {31'h0, irq_m0}, 32'h0);
        tick();
        check("m0_irq_e3", {31'h0, irq_m0}, 32'h1);
        check("m1_irq_bit1", {31'h0, irq_m1}, 32'h1);
        in_port = 18'h00001;
        tick();
        tick();
        check("m0_irq_hold", {31'h0, irq_m0}, 32'h1);
        tick();
        check("m0_irq_drop", {31'h0, irq_m0}, 32'h0);
        bus_read(ADDR_EDGE);
        check("m0_edge_rise_only", r0, 32'h2);
        bus_read(ADDR_DATA);
        check("m0_data", r0, 32'h1);

        // 6: reset pulse in the middle of a write
        bus_write(ADDR_MASK, 32'h3FFFF);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = ADDR_MASK;
        writedata  = 32'h0;
        reset_n    = 1'b0;
        #2;
        check("midreset_readdata", rd_m1, 32'h0);
        check("midreset_irq", {29'h0, irq_m1, irq_m3, irq_m0}, 32'h0);
        tick();
        reset_n    = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        repeat (4) tick();
        bus_read(ADDR_MASK);
        check("midreset_mask", r1, 32'h0);
        bus_read(ADDR_EDGE);
        check("midreset_edge_m1", r1, 32'h0);
        check("midreset_edge_m3", r3, 32'h0);
        check("midreset_irq_after", {29'h0, irq_m1, irq_m3, irq_m0}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
